// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the configurable UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Parity mismatch: even mode expects data^bit == 0, odd mode expects 1.
    function automatic logic par_mismatch(input logic data_xor,
                                          input logic sample,
                                          input int   mode);
        return (data_xor ^ sample) != (mode == PARITY_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-time counter producing mid-bit and end-of-bit ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 44
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cpb
            $error("uart_baud_tick: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_tick = (cnt_q == C_HALF);
    assign full_tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = full_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver with glitch rejection and
//               parity / framing / overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 44,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 ovr_err
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] C_LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_LAST_STOP = BW'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
            $error("uart_rx_cfg: illegal DATA_BITS / PARITY_MODE / STOP_BITS");
        end
    endgenerate

    logic                 sync1_q, rx_s_q, rx_d_q;
    rx_state_e            state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_pend_q, par_pend_d;
    logic                 frm_pend_q, frm_pend_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 ovr_err_q, ovr_err_d;
    logic                 baud_clr, baud_en, half_tick, full_tick;
    logic                 start_edge;

    assign start_edge = rx_d_q & ~rx_s_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clr       (baud_clr),
        .en        (baud_en),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_pend_d = par_pend_q;
        frm_pend_d = frm_pend_q;
        rdy_d      = rdy_q;
        rx_data_d  = rx_data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        ovr_err_d  = ovr_err_q;
        baud_clr   = 1'b0;
        baud_en    = 1'b0;

        // Acknowledge first so a same-cycle commit below takes priority.
        if (clr_rdy) begin
            rdy_d     = 1'b0;
            ovr_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                baud_clr = 1'b1;
                if (start_edge) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
            end
            START: begin
                baud_en = 1'b1;
                if (half_tick) begin
                    baud_clr = 1'b1;
                    state_d  = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                baud_en = 1'b1;
                if (full_tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == C_LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                baud_en = 1'b1;
                if (full_tick) begin
                    par_pend_d = par_mismatch(^shift_q, rx_s_q, PARITY_MODE);
                    state_d    = STOP;
                end
            end
            STOP: begin
                baud_en = 1'b1;
                if (full_tick) begin
                    if (!rx_s_q) begin
                        frm_pend_d = 1'b1;
                    end
                    if (bit_cnt_q == C_LAST_STOP) begin
                        // Commit at mid-stop so back-to-back start edges are caught.
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        par_err_d = par_pend_q;
                        frm_err_d = frm_pend_q | ~rx_s_q;
                        ovr_err_d = rdy_q & ~clr_rdy;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_d_q     <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            rdy_q      <= 1'b0;
            rx_data_q  <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            sync1_q    <= RX;
            rx_s_q     <= sync1_q;
            rx_d_q     <= rx_s_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_pend_q <= par_pend_d;
            frm_pend_q <= frm_pend_d;
            rdy_q      <= rdy_d;
            rx_data_q  <= rx_data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    assign rdy     = rdy_q;
    assign rx_data = rx_data_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule
`default_nettype wire
